mul_dispatch: RTL and testbench

MUL_DISPATCH -- requirements
Module: mul_dispatch

---
 rtl/mul_dispatch_pkg.sv | 25 ++
 rtl/mul_req_fifo.sv | 54 +++++
 rtl/mul_dispatch.sv | 122 ++++++++++++
 tb/tb_mul_dispatch.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_dispatch_pkg.sv
// Shared widths, FSM encoding and FIFO entry layout for the multiply dispatcher.
package mul_dispatch_pkg;

    localparam int DATA_W  = 32;
    localparam int PROD_W  = 64;
    localparam int ENTRY_W = 2 * DATA_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_HOLD
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } req_t;

    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mul_req_fifo.sv
// Request queue for the multiply dispatcher.
// Power-of-two depth; pointers wrap naturally, count is kept separately.
module mul_req_fifo
    import mul_dispatch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [4:0]       count,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == 5'(FIFO_DEPTH));
    assign empty   = (count == 5'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mul_dispatch.sv
// Queues operand pairs and feeds them one at a time to a multi-cycle multiplier.
// Define MUL_DISPATCH_SIGNED_EN to enable sign/magnitude handling of req_signed.
module mul_dispatch
    import mul_dispatch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic              req_signed,
    output logic [DATA_W-1:0] mul_multiplicand,
    output logic [DATA_W-1:0] mul_multiplier,
    output logic              mul_run,
    input  logic              mul_ready,
    input  logic [PROD_W-1:0] mul_product,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [PROD_W-1:0] res_product,
    output logic              busy,
    output logic [4:0]        fifo_count
);

    state_t            state;
    state_t            state_nx;
    req_t              wr_ent;
    req_t              head;
    logic              pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic              rdy_q;
    logic              neg_q;
    logic              head_neg;
    logic              ready_rise;
    logic [DATA_W-1:0] head_a;
    logic [DATA_W-1:0] head_b;
    logic [PROD_W-1:0] prod_fix;

    mul_req_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .WIDTH     (ENTRY_W)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (req_valid && req_ready),
        .wdata(wr_ent),
        .pop  (pop),
        .rdata(head),
        .count(fifo_count),
        .empty(fifo_empty),
        .full (fifo_full)
    );

`ifdef MUL_DISPATCH_SIGNED_EN
    assign wr_ent   = '{sign: req_signed, a: req_a, b: req_b};
    assign head_a   = head.sign ? mag(head.a) : head.a;
    assign head_b   = head.sign ? mag(head.b) : head.b;
    assign head_neg = head.sign && (head.a[DATA_W-1] ^ head.b[DATA_W-1]);
    assign prod_fix = neg_q ? (~mul_product + 1'b1) : mul_product;
`else
    logic unused_sign;
    assign unused_sign = req_signed ^ head.sign ^ neg_q;
    assign wr_ent      = '{sign: 1'b0, a: req_a, b: req_b};
    assign head_a      = head.a;
    assign head_b      = head.b;
    assign head_neg    = 1'b0;
    assign prod_fix    = mul_product;
`endif

    assign req_ready  = !fifo_full;
    assign mul_run    = (state == ST_LAUNCH);
    assign busy       = (state != ST_IDLE) || !fifo_empty;
    // A level already high when WAIT is entered must not count as done.
    assign ready_rise = mul_ready && !rdy_q;

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_nx = ST_WAIT;
            ST_WAIT:   if (ready_rise) state_nx = ST_HOLD;
            ST_HOLD:   if (res_ready) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            rdy_q            <= 1'b0;
            neg_q            <= 1'b0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
            res_product      <= '0;
            res_valid        <= 1'b0;
        end else begin
            state <= state_nx;
            rdy_q <= mul_ready;
            if (pop) begin
                mul_multiplicand <= head_a;
                mul_multiplier   <= head_b;
                neg_q            <= head_neg;
            end
            if (state == ST_WAIT && ready_rise) begin
                res_product <= prod_fix;
                res_valid   <= 1'b1;
            end else if (state == ST_HOLD && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mul_dispatch.sv
// Directed plus randomized bench for mul_dispatch with a behavioural multiplier.
module tb_mul_dispatch;

    localparam int DEPTH = 4;
`ifdef MUL_DISPATCH_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        req_signed = 1'b0;
    logic [31:0] mul_multiplicand;
    logic [31:0] mul_multiplier;
    logic        mul_run;
    logic        mul_ready = 1'b0;
    logic [63:0] mul_product = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [63:0] res_product;
    logic        busy;
    logic [4:0]  fifo_count;

    always #5 clk = ~clk;

    mul_dispatch #(.FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_a           (req_a),
        .req_b           (req_b),
        .req_signed      (req_signed),
        .mul_multiplicand(mul_multiplicand),
        .mul_multiplier  (mul_multiplier),
        .mul_run         (mul_run),
        .mul_ready       (mul_ready),
        .mul_product     (mul_product),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_product     (res_product),
        .busy            (busy),
        .fifo_count      (fifo_count)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } exp_t;

    exp_t        opq[$];
    logic [63:0] pq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          run_cnt = 0;
    int          res_cnt = 0;
    int          push_cnt = 0;

    // multiplier model state
    int          lat = 33;
    int          cur_lat = 33;
    int          stale = 0;
    int          cnt = 0;
    bit          active = 1'b0;
    bit          pre_high = 1'b0;
    bit          rand_lat = 1'b0;
    bit          run_seen = 1'b0;
    logic [31:0] ma = '0;
    logic [31:0] mb = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ref_req(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t   e;
        longint sa;
        longint sb;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        e.a = a;
        e.b = b;
        e.p = {32'b0, a} * {32'b0, b};
        if (s && SGN) begin
            e.a = 32'(sa < 0 ? -sa : sa);
            e.b = 32'(sb < 0 ? -sb : sb);
            e.p = 64'(sa * sb);
        end
        return e;
    endfunction

    task automatic cyc();
        exp_t e;
        @(negedge clk);
        run_seen = mul_run;
        if (mul_run) begin
            run_cnt++;
            chk("run_expected", 64'(opq.size() != 0), 64'd1);
            if (opq.size() != 0) begin
                chk("run_a", 64'(mul_multiplicand), 64'(opq[0].a));
                chk("run_b", 64'(mul_multiplier), 64'(opq[0].b));
                void'(opq.pop_front());
            end
            ma = mul_multiplicand;
            mb = mul_multiplier;
        end
        if (res_valid && res_ready) begin
            res_cnt++;
            chk("res_expected", 64'(pq.size() != 0), 64'd1);
            if (pq.size() != 0) chk("res_prod", res_product, pq.pop_front());
        end
        if (req_valid && req_ready) begin
            push_cnt++;
            e = ref_req(req_a, req_b, req_signed);
            opq.push_back(e);
            pq.push_back(e.p);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            active    = 1'b0;
            mul_ready = 1'b0;
        end else if (run_seen) begin
            active      = 1'b1;
            cnt         = 0;
            cur_lat     = rand_lat ? int'($urandom_range(1, 6)) : lat;
            mul_ready   = (stale > 0);
            mul_product = 64'hBAD0_BAD0_BAD0_BAD0;
        end else if (active) begin
            cnt++;
            if (stale > 0 && cnt == stale) mul_ready = 1'b0;
            if (cnt == cur_lat) begin
                chk("stable_a", 64'(mul_multiplicand), 64'(ma));
                chk("stable_b", 64'(mul_multiplier), 64'(mb));
                mul_ready   = 1'b1;
                mul_product = {32'b0, ma} * {32'b0, mb};
                active      = 1'b0;
            end
        end else if (pre_high) begin
            mul_ready = 1'b1;
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic s);
        req_a      = a;
        req_b      = b;
        req_signed = s;
        req_valid  = 1'b1;
        cyc();
        req_valid  = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int i = 0;
        while (!res_valid && i < budget) begin
            cyc();
            i++;
        end
        chk("valid_timeout", 64'(res_valid), 64'd1);
    endtask

    task automatic wait_res(input int target, input int budget);
        int i = 0;
        while ((res_cnt < target || busy) && i < budget) begin
            cyc();
            i++;
        end
        chk("drain_count", 64'(res_cnt), 64'(target));
        chk("drain_idle", 64'(busy), 64'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_run"}, 64'(mul_run), 64'd0);
        chk({tag, "_rv"}, 64'(res_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_prod"}, res_product, 64'd0);
        chk({tag, "_mcand"}, 64'(mul_multiplicand), 64'd0);
        chk({tag, "_mplier"}, 64'(mul_multiplier), 64'd0);
        chk({tag, "_cnt"}, 64'(fifo_count), 64'd0);
    endtask

    initial begin
        int base;
        int target;

        // reset state
        cyc();
        cyc();
        chk_zero("reset");
        rst = 1'b0;
        cyc();
        chk("ready_after_reset", 64'(req_ready), 64'd1);

        // single 7*6, slow multiplier, stalled consumer
        lat = 33;
        push(32'd7, 32'd6, 1'b0);
        cyc();
        chk("no_run_yet", 64'(run_cnt), 64'd0);
        cyc();
        chk("one_run", 64'(run_cnt), 64'd1);
        for (int i = 0; i < 33; i++) cyc();
        chk("rv_before_rise", 64'(res_valid), 64'd0);
        cyc();
        chk("rv_after_rise", 64'(res_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_rv", 64'(res_valid), 64'd1);
            chk("hold_prod", res_product, 64'd42);
        end
        res_ready = 1'b1;
        cyc();
        chk("rv_cleared", 64'(res_valid), 64'd0);
        chk("single_runs", 64'(run_cnt), 64'd1);

        // five back-to-back, consumer stalled
        res_ready = 1'b0;
        lat       = 3;
        target    = res_cnt + 5;
        for (int i = 0; i < 5; i++) push($urandom, $urandom, 1'(i % 2));
        chk("full_count", 64'(fifo_count), 64'(DEPTH));
        chk("full_ready", 64'(req_ready), 64'd0);
        req_valid = 1'b1;
        req_a     = 32'd99;
        cyc();
        req_valid = 1'b0;
        chk("full_no_push", 64'(fifo_count), 64'(DEPTH));
        wait_valid(50);
        res_ready = 1'b1;
        wait_res(target, 200);

        // stale mul_ready before launch
        res_ready = 1'b0;
        pre_high  = 1'b1;
        stale     = 5;
        lat       = 10;
        cyc();
        cyc();
        chk("pre_high", 64'(mul_ready), 64'd1);
        push(32'd1234, 32'd5678, 1'b0);
        cyc();
        cyc();
        for (int k = 1; k <= 10; k++) begin
            cyc();
            chk("stale_no_hold", 64'(res_valid), 64'd0);
        end
        cyc();
        chk("stale_rv", 64'(res_valid), 64'd1);
        chk("stale_prod", res_product, 64'd7006652);
        pre_high  = 1'b0;
        stale     = 0;
        res_ready = 1'b1;
        cyc();

        // signed -3 * 5
        res_ready = 1'b0;
        lat       = 4;
        push(32'hFFFF_FFFD, 32'd5, 1'b1);
        cyc();
        cyc();
        chk("sgn_mcand", 64'(mul_multiplicand), SGN ? 64'd3 : 64'hFFFF_FFFD);
        chk("sgn_mplier", 64'(mul_multiplier), 64'd5);
        wait_valid(20);
        chk("sgn_prod", res_product,
            SGN ? 64'hFFFF_FFFF_FFFF_FFF1 : 64'h0000_0004_FFFF_FFF1);
        res_ready = 1'b1;
        cyc();

        // reset during WAIT with two queued
        lat = 20;
        push(32'd3, 32'd4, 1'b0);
        push(32'd5, 32'd6, 1'b0);
        push(32'd7, 32'd8, 1'b0);
        cyc();
        cyc();
        chk("pre_rst_cnt", 64'(fifo_count), 64'd2);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #2;
        chk_zero("mid_rst");
        opq.delete();
        pq.delete();
        cyc();
        rst = 1'b0;
        cyc();
        chk("post_rst_ready", 64'(req_ready), 64'd1);
        target = res_cnt + 1;
        push(32'd9, 32'd11, 1'b0);
        wait_valid(40);
        chk("post_rst_prod", res_product, 64'd99);
        wait_res(target, 40);

        // randomized traffic
        rand_lat = 1'b1;
        base     = push_cnt;
        for (int i = 0; i < 400 && push_cnt - base < 20; i++) begin
            req_valid  = 1'($urandom_range(0, 1));
            req_a      = $urandom;
            req_b      = $urandom;
            req_signed = 1'($urandom_range(0, 1));
            res_ready  = 1'($urandom_range(0, 1));
            cyc();
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        chk("rand_pushed", 64'(push_cnt - base), 64'd20);
        wait_res(res_cnt + opq.size() + pq.size() - opq.size(), 600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
